// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state and action encodings,
// and the fill used to build the default bubble payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOADED = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_ADV    = 2'd3
  } action_t;

  // A bubble payload defaults to every bit equal to NOP_FILL.
  localparam logic NOP_FILL        = 1'b0;
  localparam int   NOP_DEFAULT_W   = 70;
  localparam logic [NOP_DEFAULT_W-1:0] NOP_DEFAULT = {NOP_DEFAULT_W{NOP_FILL}};

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign q = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/bubble/flush control and event statistics.
// One action is decoded per cycle and applied in a single registered update.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 70,
  parameter int               STALL_W   = 6,
  parameter int               STAGE     = 3,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{NOP_FILL}},
  parameter int               CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   hold_run
);

  logic             w_up;
  logic             w_dn;
  logic             w_unused_stall;
  action_t          w_act;
  logic             w_valid_next;
  logic [WIDTH-1:0] w_data_next;
  state_t           w_state_next;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  state_t           r_state;

  assign w_up = stall[STAGE];

  // The last stage has no downstream stall bit, so it can only bubble, never hold.
  generate
    if (STAGE < STALL_W - 1) begin : g_dn
      assign w_dn = stall[STAGE+1];
    end else begin : g_dn_top
      assign w_dn = 1'b0;
    end
  endgenerate

  assign w_unused_stall = ^stall;

  always_comb begin
    w_act = ACT_ADV;
    if (flush) begin
      w_act = ACT_FLUSH;
    end else if (w_up && !w_dn) begin
      w_act = ACT_BUBBLE;
    end else if (w_up) begin
      w_act = ACT_HOLD;
    end

    w_valid_next = r_valid;
    w_data_next  = r_data;
    w_state_next = r_state;
    case (w_act)
      ACT_FLUSH, ACT_BUBBLE: begin
        w_valid_next = 1'b0;
        w_data_next  = NOP_VALUE;
        w_state_next = ST_EMPTY;
      end
      ACT_HOLD: begin
        w_state_next = (r_state == ST_EMPTY) ? ST_EMPTY : ST_HELD;
      end
      ACT_ADV: begin
        w_valid_next = in_valid;
        w_data_next  = in_valid ? in_data : NOP_VALUE;
        w_state_next = in_valid ? ST_LOADED : ST_EMPTY;
      end
      default: begin
        w_valid_next = 1'b0;
        w_data_next  = NOP_VALUE;
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VALUE;
      r_state <= ST_EMPTY;
    end else begin
      r_valid <= w_valid_next;
      r_data  <= w_data_next;
      r_state <= w_state_next;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign state     = r_state;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (w_act == ACT_BUBBLE),
    .q     (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (w_act == ACT_HOLD),
    .q     (hold_cnt)
  );

  // The run length restarts on any non-hold action and ignores cnt_clr.
  sat_counter #(.W(CNT_W)) u_hold_run (
    .clk   (clk),
    .reset (reset),
    .clr   (w_act != ACT_HOLD),
    .inc   (w_act == ACT_HOLD),
    .q     (hold_run)
  );

endmodule
